// File: rtl/ps2_keypad_decoder_if.sv
// Keyboard-pin and decoded-action bundle between the PS/2 decoder and the game logic.
// The master side is the decoder; the slave side is the keyboard pins plus the consumer.
interface ps2_keypad_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] user_value;
    logic       value_valid;
    logic       cursor_up;
    logic       cursor_down;
    logic       cursor_left;
    logic       cursor_right;
    logic       frame_error;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output user_value,
        output value_valid,
        output cursor_up,
        output cursor_down,
        output cursor_left,
        output cursor_right,
        output frame_error
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  user_value,
        input  value_valid,
        input  cursor_up,
        input  cursor_down,
        input  cursor_left,
        input  cursor_right,
        input  frame_error
    );
endinterface

// File: rtl/ps2_keypad_decoder.sv
// PS/2 scan-code-set-2 receiver: synchronises the keyboard pins, deframes bytes and
// turns make codes into sudoku digit entries and cursor-move pulses.
module ps2_keypad_decoder #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    ps2_keypad_decoder_if.master  kbd
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    // ------------------------------------------------------------------
    // Pin synchronisers and registered falling-edge detect
    // ------------------------------------------------------------------
    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;
    logic       fall_q;
    logic       bit_q;

    // Sync flops reset to the idle-high line level so release of reset never looks like an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
            fall_q    <= 1'b0;
            bit_q     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every stage read the previous cycle's value,
            // which is what makes this a real shift chain rather than one collapsed flop.
            clk_sync  <= {clk_sync[0], kbd.ps2_clk};
            data_sync <= {data_sync[0], kbd.ps2_data};
            clk_prev  <= clk_sync[1];
            fall_q    <= clk_prev & ~clk_sync[1];
            bit_q     <= data_sync[1];
        end
    end

    // ------------------------------------------------------------------
    // Frame deserialiser with inter-edge timeout
    // ------------------------------------------------------------------
    logic [1:0]       state;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             parity_bit;
    logic [CNT_W-1:0] tmo_cnt;
    logic             byte_stb;
    logic [7:0]       byte_q;
    logic             err_stb;
    logic             err_flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tmo_cnt    <= '0;
            byte_stb   <= 1'b0;
            byte_q     <= '0;
            err_stb    <= 1'b0;
            err_flush  <= 1'b0;
        end else begin
            byte_stb  <= 1'b0;
            err_stb   <= 1'b0;
            err_flush <= 1'b0;

            if (state == ST_IDLE) begin
                tmo_cnt <= '0;
                if (fall_q) begin
                    if (!bit_q) begin
                        state     <= ST_DATA;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end else begin
                        // Bad start bit: report it but leave any pending E0/F0 prefix alone.
                        err_stb <= 1'b1;
                    end
                end
            end else if (fall_q) begin
                tmo_cnt <= '0;
                if (state == ST_DATA) begin
                    shift_reg <= {bit_q, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        state <= ST_PARITY;
                    end
                end else if (state == ST_PARITY) begin
                    parity_bit <= bit_q;
                    state      <= ST_STOP;
                end else begin
                    if (bit_q && ((^shift_reg) ^ parity_bit)) begin
                        byte_stb <= 1'b1;
                        byte_q   <= shift_reg;
                    end else begin
                        err_stb   <= 1'b1;
                        err_flush <= 1'b1;
                    end
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                end
            end else if (tmo_cnt == TIMEOUT_LIMIT) begin
                // Keyboard went quiet mid-frame: drop the partial byte silently.
                state     <= ST_IDLE;
                bit_cnt   <= '0;
                shift_reg <= '0;
                tmo_cnt   <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan-code decoder and registered outputs
    // ------------------------------------------------------------------
    function automatic logic [4:0] digit_of(input logic [7:0] code);
        logic [4:0] res;
        res = 5'd0;
        case (code)
            8'h16, 8'h69: res = {1'b1, 4'd1};
            8'h1E, 8'h72: res = {1'b1, 4'd2};
            8'h26, 8'h7A: res = {1'b1, 4'd3};
            8'h25, 8'h6B: res = {1'b1, 4'd4};
            8'h2E, 8'h73: res = {1'b1, 4'd5};
            8'h36, 8'h74: res = {1'b1, 4'd6};
            8'h3D, 8'h6C: res = {1'b1, 4'd7};
            8'h3E, 8'h75: res = {1'b1, 4'd8};
            8'h46, 8'h7D: res = {1'b1, 4'd9};
            8'h45, 8'h70, 8'h66: res = {1'b1, 4'd0};
            default: res = 5'd0;
        endcase
        return res;
    endfunction

    logic [4:0] digit_hit;
    assign digit_hit = digit_of(byte_q);

    logic       ext_flag;
    logic       brk_flag;
    logic [3:0] user_value_q;
    logic       value_valid_q;
    logic       up_q;
    logic       down_q;
    logic       left_q;
    logic       right_q;
    logic       frame_error_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ext_flag      <= 1'b0;
            brk_flag      <= 1'b0;
            user_value_q  <= '0;
            value_valid_q <= 1'b0;
            up_q          <= 1'b0;
            down_q        <= 1'b0;
            left_q        <= 1'b0;
            right_q       <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            value_valid_q <= 1'b0;
            up_q          <= 1'b0;
            down_q        <= 1'b0;
            left_q        <= 1'b0;
            right_q       <= 1'b0;
            frame_error_q <= 1'b0;

            if (err_stb) begin
                frame_error_q <= 1'b1;
                if (err_flush) begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end
            end else if (byte_stb) begin
                if (byte_q == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else if (brk_flag) begin
                    // Key releases carry no action.
                    brk_flag <= 1'b0;
                    ext_flag <= 1'b0;
                end else if (ext_flag) begin
                    ext_flag <= 1'b0;
                    case (byte_q)
                        8'h75:   up_q    <= 1'b1;
                        8'h72:   down_q  <= 1'b1;
                        8'h6B:   left_q  <= 1'b1;
                        8'h74:   right_q <= 1'b1;
                        default: ;
                    endcase
                end else if (digit_hit[4]) begin
                    user_value_q  <= digit_hit[3:0];
                    value_valid_q <= 1'b1;
                end
            end
        end
    end

    assign kbd.user_value   = user_value_q;
    assign kbd.value_valid  = value_valid_q;
    assign kbd.cursor_up    = up_q;
    assign kbd.cursor_down  = down_q;
    assign kbd.cursor_left  = left_q;
    assign kbd.cursor_right = right_q;
    assign kbd.frame_error  = frame_error_q;

endmodule

// File: tb/tb_ps2_keypad_decoder.sv
// Self-checking bench for ps2_keypad_decoder: table of keyboard frames with a pulse scoreboard,
// plus hand-written reset, timeout and mid-frame-reset sequences.
module tb_ps2_keypad_decoder;

    localparam int TMO  = 1000;
    localparam int HALF = 15;

    localparam logic [5:0] P_NONE = 6'b000000;
    localparam logic [5:0] P_VV   = 6'b100000;
    localparam logic [5:0] P_UP   = 6'b010000;
    localparam logic [5:0] P_DN   = 6'b001000;
    localparam logic [5:0] P_LT   = 6'b000100;
    localparam logic [5:0] P_RT   = 6'b000010;
    localparam logic [5:0] P_ERR  = 6'b000001;

    typedef struct packed {
        logic [5:0] pulses;
        logic [3:0] uv;
    } exp_t;

    typedef struct packed {
        logic [7:0] code;
        logic       flip;
        logic [5:0] pulses;
        logic [3:0] uv;
    } vec_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   stop_cyc = 0;
    exp_t sb[$];
    vec_t vecs[$];

    ps2_keypad_decoder_if bus ();

    ps2_keypad_decoder #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (16)
    ) dut (
        .clock(clk),
        .reset(rst),
        .kbd  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every output pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        logic [5:0] p;
        exp_t e;
        p = {bus.value_valid, bus.cursor_up, bus.cursor_down,
             bus.cursor_left, bus.cursor_right, bus.frame_error};
        if (!rst && p != 6'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'(p), 32'(P_NONE));
            end else begin
                e = sb.pop_front();
                check("pulse_kind", 32'(p), 32'(e.pulses));
                check("pulse_value", 32'(bus.user_value), 32'(e.uv));
                check("pulse_latency", 32'(cyc - stop_cyc), 32'd5);
            end
        end
    end

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        @(negedge clk);
        bus.ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic flip);
        logic par;
        par = ~(^code) ^ flip;
        send_bits({1'b1, par, code, 1'b0}, 11);
    endtask

    task automatic drain(input string name);
        repeat (12) @(negedge clk);
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_uv"}, 32'(bus.user_value), 32'd0);
        check({tag, "_pulses"}, 32'({bus.value_valid, bus.cursor_up, bus.cursor_down,
              bus.cursor_left, bus.cursor_right, bus.frame_error}), 32'd0);
    endtask

    function automatic void add(input logic [7:0] code, input logic flip,
                                input logic [5:0] pulses, input logic [3:0] uv);
        vec_t v;
        v.code = code;
        v.flip = flip;
        v.pulses = pulses;
        v.uv = uv;
        vecs.push_back(v);
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        exp_t e;
        // code, parity flip, expected pulse, user_value held afterwards
        add(8'h2E, 1'b0, P_VV,   4'd5);
        add(8'hF0, 1'b0, P_NONE, 4'd5);
        add(8'h2E, 1'b0, P_NONE, 4'd5);
        add(8'hE0, 1'b0, P_NONE, 4'd5);
        add(8'h75, 1'b0, P_UP,   4'd5);
        add(8'h75, 1'b0, P_VV,   4'd8);
        add(8'hE0, 1'b0, P_NONE, 4'd8);
        add(8'h72, 1'b0, P_DN,   4'd8);
        add(8'h72, 1'b0, P_VV,   4'd2);
        add(8'hE0, 1'b0, P_NONE, 4'd2);
        add(8'h6B, 1'b0, P_LT,   4'd2);
        add(8'h6B, 1'b0, P_VV,   4'd4);
        add(8'hE0, 1'b0, P_NONE, 4'd4);
        add(8'h74, 1'b0, P_RT,   4'd4);
        add(8'h74, 1'b0, P_VV,   4'd6);
        add(8'h16, 1'b1, P_ERR,  4'd6);
        add(8'h26, 1'b0, P_VV,   4'd3);
        add(8'h7D, 1'b0, P_VV,   4'd9);
        add(8'h66, 1'b0, P_VV,   4'd0);
        add(8'h3D, 1'b0, P_VV,   4'd7);
        add(8'h45, 1'b0, P_VV,   4'd0);
        add(8'h1C, 1'b0, P_NONE, 4'd0);
        add(8'hE0, 1'b0, P_NONE, 4'd0);
        add(8'h7D, 1'b0, P_NONE, 4'd0);
        add(8'h7D, 1'b0, P_VV,   4'd9);
        add(8'hE0, 1'b0, P_NONE, 4'd9);
        add(8'hF0, 1'b0, P_NONE, 4'd9);
        add(8'h75, 1'b0, P_NONE, 4'd9);
        add(8'h6C, 1'b0, P_VV,   4'd7);
        add(8'hE0, 1'b0, P_NONE, 4'd7);
        add(8'h16, 1'b1, P_ERR,  4'd7);
        add(8'h75, 1'b0, P_VV,   4'd8);
        add(8'h69, 1'b0, P_VV,   4'd1);
        add(8'h7A, 1'b0, P_VV,   4'd3);
        add(8'h73, 1'b0, P_VV,   4'd5);
        add(8'h70, 1'b0, P_VV,   4'd0);

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_idle_outputs("post_reset");

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].pulses != P_NONE) begin
                e.pulses = vecs[i].pulses;
                e.uv = vecs[i].uv;
                sb.push_back(e);
            end
            send_frame(vecs[i].code, vecs[i].flip);
            drain($sformatf("vec%0d_drain", i));
            check($sformatf("vec%0d_uv", i), 32'(bus.user_value), 32'(vecs[i].uv));
        end

        // Timeout: start plus four data bits, then silence; the next frame must stand alone.
        send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 5);
        repeat (TMO + 10) @(negedge clk);
        check("timeout_quiet", 32'(sb.size()), 32'd0);
        e.pulses = P_VV;
        e.uv = 4'd2;
        sb.push_back(e);
        send_frame(8'h1E, 1'b0);
        drain("timeout_drain");
        check("timeout_uv", 32'(bus.user_value), 32'd2);

        // Reset after six bits of 3E: outputs clear at once, no 3E pulse ever appears.
        send_bits({1'b1, 1'b0, 8'h3E, 1'b0}, 6);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_uv", 32'(bus.user_value), 32'd0);
        repeat (10) @(negedge clk);
        bus.ps2_data = 1'b1;
        rst = 1'b0;
        e.pulses = P_VV;
        e.uv = 4'd9;
        sb.push_back(e);
        send_frame(8'h46, 1'b0);
        drain("midreset_drain");
        check("midreset_uv", 32'(bus.user_value), 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
